// File: rtl/nn_pkg.sv
// Shared types and defaults for the node-layer sequencer and its image buffer.
package nn_pkg;

  typedef logic [15:0] fix_t;

  localparam int unsigned DEF_IMAGE_SIZE = 64;
  localparam int unsigned DEF_NUM_NODES  = 16;
  localparam int unsigned CNT_W          = 7;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    ACCUM,
    SETTLE,
    OUT
  } state_e;

endpackage

// File: rtl/image_buffer.sv
// Image word store: one serial write port, all words visible in parallel.
module image_buffer
  import nn_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = DEF_IMAGE_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en_i,
  input  logic [CNT_W-1:0]                 wr_idx_i,
  input  fix_t                             wr_data_i,
  output fix_t [IMAGE_SIZE-1:0]            rd_data_o
);

  fix_t [IMAGE_SIZE-1:0] mem_q, mem_d;

  // Compare against each slot so the index width never has to match the array depth.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
      if (wr_en_i && (wr_idx_i == CNT_W'(i))) begin
        mem_d[i] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q;

endmodule

// File: rtl/node_layer_ctrl.sv
// Loads an image, steps a node layer through one MAC per word, then captures
// and hands off the layer's activations with a valid/ready handshake.
module node_layer_ctrl
  import nn_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = DEF_IMAGE_SIZE,
  parameter int unsigned NUM_NODES  = DEF_NUM_NODES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  fix_t                        pix_in,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output fix_t [IMAGE_SIZE-1:0]       img_data,
  output logic [CNT_W-1:0]            cnt_val,
  output logic                        reset_acc,
  output logic                        start,
  input  fix_t [NUM_NODES-1:0]        node_out_in,
  output fix_t [NUM_NODES-1:0]        layer_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  if (IMAGE_SIZE < 1 || IMAGE_SIZE > 128) begin : g_bad_image_size
    $error("node_layer_ctrl: IMAGE_SIZE must be within 1..128");
  end

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(IMAGE_SIZE - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       widx_q, widx_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  fix_t [NUM_NODES-1:0]   layer_out_q, layer_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   wr_en;

  assign wr_en = (state_q == LOAD) && pix_valid && !rst;

  image_buffer #(
    .IMAGE_SIZE (IMAGE_SIZE)
  ) u_image_buffer (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (widx_q),
    .wr_data_i (pix_in),
    .rd_data_o (img_data)
  );

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    idx_d       = idx_q;
    layer_out_d = layer_out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      LOAD: begin
        if (pix_valid) begin
          if (widx_q == LastIdx) begin
            widx_d  = '0;
            state_d = CLEAR;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        idx_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = SETTLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SETTLE: begin
        // Node accumulators are final only now; this is the single capture point.
        layer_out_d = node_out_in;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      widx_q      <= '0;
      idx_q       <= '0;
      layer_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      idx_q       <= idx_d;
      layer_out_q <= layer_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Node controls are forced to their cleared/hold values while rst is asserted.
  assign pix_ready = (state_q == LOAD) && !rst;
  assign reset_acc = rst || (state_q == CLEAR);
  assign start     = rst || (state_q != ACCUM);
  assign cnt_val   = (!rst && state_q == ACCUM) ? idx_q : '0;
  assign busy      = (state_q != LOAD);
  assign layer_out = layer_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_node_layer_ctrl.sv
// Directed bench for node_layer_ctrl with a node-layer stub that only presents
// the expected results during the settle cycle.
module tb_node_layer_ctrl;

  localparam int IMG = 64;
  localparam int NN  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [15:0]           pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [IMG-1:0][15:0]  img_data;
  logic [6:0]            cnt_val;
  logic                  reset_acc;
  logic                  start;
  logic [NN-1:0][15:0]   node_out_in;
  logic [NN-1:0][15:0]   layer_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_last;
  int ready_cnt;
  int early;
  logic prev_start = 1'b1;

  node_layer_ctrl #(
    .IMAGE_SIZE (IMG),
    .NUM_NODES  (NN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .img_data    (img_data),
    .cnt_val     (cnt_val),
    .reset_acc   (reset_acc),
    .start       (start),
    .node_out_in (node_out_in),
    .layer_out   (layer_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_start <= start;
  end

  // Stub: 0xFFFF while accumulating, A000+j only in the first hold cycle after it.
  always_comb begin
    node_out_in = '0;
    for (int j = 0; j < NN; j++) begin
      if (!start) node_out_in[j] = 16'hFFFF;
      else if (!prev_start) node_out_in[j] = 16'(32'hA000 + j);
      else node_out_in[j] = 16'h5555;
    end
  end

  // Presents IMG words base+k, with `gap` idle cycles before each word.
  task automatic load_image(input logic [15:0] base, input int gap);
    ready_cnt = 0;
    early = 0;
    for (int k = 0; k < IMG; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        pix_valid = 1'b0;
        if (reset_acc) early++;
      end
      @(negedge clk);
      if (reset_acc) early++;
      pix_valid = 1'b1;
      pix_in    = 16'(base + 16'(k));
      if (pix_ready) ready_cnt++;
      t_last = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (reset_acc !== 1'b1) begin
        fails++; $display("FAIL reset_acc_in_rst: got %b want 1", reset_acc);
      end
      tests++;
      if (pix_ready !== 1'b0) begin
        fails++; $display("FAIL pix_ready_in_rst: got %b want 0", pix_ready);
      end
      if (i == 1) rst = 1'b0;
    end
    @(negedge clk);
    tests++;
    if ({pix_ready, out_valid, busy} !== 3'b100) begin
      fails++; $display("FAIL after_rst ready/valid/busy: got %b want 100",
                        {pix_ready, out_valid, busy});
    end
    tests++;
    if (layer_out !== '0) begin
      fails++; $display("FAIL after_rst layer_out: got %h want 0", layer_out);
    end
  endtask

  task automatic test_load_accum();
    int errs;
    load_image(16'h0000, 0);
    tests++;
    if (ready_cnt !== IMG) begin
      fails++; $display("FAIL load_ready_cycles: got %0d want %0d", ready_cnt, IMG);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    errs = 0;
    for (int k = 0; k < IMG; k++) if (img_data[k] !== 16'(k)) errs++;
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL load_img_data: got %0d bad words want 0", errs);
    end
    tests++;
    if ({reset_acc, start, cnt_val} !== {2'b11, 7'd0}) begin
      fails++; $display("FAIL clear_cycle: got acc=%b start=%b cnt=%0d want 1 1 0",
                        reset_acc, start, cnt_val);
    end
    errs = 0;
    for (int i = 0; i < IMG; i++) begin
      @(negedge clk);
      if (start !== 1'b0 || reset_acc !== 1'b0 || cnt_val !== 7'(i)) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL accum_steps: got %0d bad cycles want 0", errs);
    end
    @(negedge clk);
    tests++;
    if ({start, reset_acc, cnt_val, out_valid} !== {2'b10, 7'd0, 1'b0}) begin
      fails++; $display("FAIL settle_cycle: got start=%b acc=%b cnt=%0d valid=%b want 1 0 0 0",
                        start, reset_acc, cnt_val, out_valid);
    end
  endtask

  task automatic test_capture();
    int n;
    int errs;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    tests++;
    if (out_valid !== 1'b1 || (cyc - t_last) != 67) begin
      fails++; $display("FAIL capture_latency: got valid=%b lat=%0d want 1 67",
                        out_valid, cyc - t_last);
    end
    errs = 0;
    for (int j = 0; j < NN; j++) if (layer_out[j] !== 16'(32'hA000 + j)) errs++;
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL capture_values: got %0d bad nodes want 0 (%h)", errs, layer_out);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, pix_ready, busy} !== 3'b010) begin
      fails++; $display("FAIL capture_handoff valid/ready/busy: got %b want 010",
                        {out_valid, pix_ready, busy});
    end
  endtask

  task automatic test_backpressure();
    int n;
    int errs;
    out_ready = 1'b0;
    load_image(16'h0100, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (out_valid !== 1'b1 || (cyc - t_last) != 67) begin
      fails++; $display("FAIL bp_latency: got valid=%b lat=%0d want 1 67",
                        out_valid, cyc - t_last);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid !== 1'b1 || pix_ready !== 1'b0 || start !== 1'b1 || cnt_val !== 7'd0)
        errs++;
      for (int j = 0; j < NN; j++) if (layer_out[j] !== 16'(32'hA000 + j)) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL bp_hold: got %0d bad signals want 0", errs);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_still_valid: got %b want 1", out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, pix_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_release valid/ready: got %b want 01", {out_valid, pix_ready});
    end
  endtask

  task automatic test_gapped();
    int errs;
    int n;
    load_image(16'h1234, 2);
    tests++;
    if (early != 0 || ready_cnt != IMG) begin
      fails++; $display("FAIL gap_load: got early=%0d ready=%0d want 0 %0d",
                        early, ready_cnt, IMG);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    tests++;
    if (reset_acc !== 1'b1) begin
      fails++; $display("FAIL gap_clear: got %b want 1", reset_acc);
    end
    errs = 0;
    for (int k = 0; k < IMG; k++) if (img_data[k] !== 16'(16'h1234 + k)) errs++;
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL gap_img_data: got %0d bad words want 0", errs);
    end
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if ((cyc - t_last) != 67) begin
      fails++; $display("FAIL gap_latency: got %0d want 67", cyc - t_last);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int errs;
    load_image(16'h2000, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    n = 0;
    while (!(start === 1'b0 && cnt_val === 7'd30) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (cnt_val !== 7'd30) begin
      fails++; $display("FAIL mid_reach_30: got %0d want 30", cnt_val);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({pix_ready, busy, out_valid} !== 3'b100) begin
      fails++; $display("FAIL mid_after_rst ready/busy/valid: got %b want 100",
                        {pix_ready, busy, out_valid});
    end
    tests++;
    if (img_data !== '0) begin
      fails++; $display("FAIL mid_img_clear: got nonzero image want 0");
    end
    load_image(16'h0000, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (out_valid !== 1'b1 || (cyc - t_last) != 67) begin
      fails++; $display("FAIL mid_rerun_latency: got valid=%b lat=%0d want 1 67",
                        out_valid, cyc - t_last);
    end
    errs = 0;
    for (int j = 0; j < NN; j++) if (layer_out[j] !== 16'(32'hA000 + j)) errs++;
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL mid_rerun_values: got %0d bad nodes want 0", errs);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_accum();
    test_capture();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/node_layer_ctrl.md
Name: node_layer_ctrl

Overview:
- Sequencer that sits directly upstream of a layer of `node` instances and also collects their outputs.
- Accepts an input image one 16-bit word per handshake into an internal buffer, then presents the whole image in parallel to the nodes.
- Drives the nodes' shared reset_acc / start / cnt_val controls to run one multiply-accumulate per image word.
- Captures every node's activation output into a registered result vector and hands it downstream with a valid/ready handshake.

Parameters:
- IMAGE_SIZE, 64, words per image and accumulate steps per run; legal range 1..128 because cnt_val is 7 bits; elaboration error outside this range.
- NUM_NODES, 16, number of node instances driven and captured.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- pix_in  input  16  image word to load
- pix_valid  input  1  pix_in valid
- pix_ready  output  1  buffer accepting words; a word transfers on a cycle with pix_valid && pix_ready
- img_data  output  16 x IMAGE_SIZE  buffered image, parallel to every node's data_in
- cnt_val  output  7  word/coefficient index for the nodes
- reset_acc  output  1  clears node accumulators
- start  output  1  node hold control: 0 = accumulate, 1 = hold
- node_out_in  input  16 x NUM_NODES  activation outputs from the nodes
- layer_out  output  16 x NUM_NODES  registered captured results
- out_valid  output  1  layer_out valid
- out_ready  input  1  downstream accepts layer_out
- busy  output  1  high in every state except LOAD

Behaviour:
- Reset (rst high at a clock edge):
  - State becomes LOAD; write index widx=0; step index idx=0.
  - img_data, layer_out and out_valid are all cleared to 0.
  - While rst is high, reset_acc=1, start=1, cnt_val=0 and pix_ready=0.
  - Reset mid-operation aborts the run without producing output.
- LOAD:
  - pix_ready=1.
  - Each handshake writes pix_in to img_data[widx] and increments widx.
  - A handshake with widx==IMAGE_SIZE-1 moves to CLEAR and resets widx to 0.
  - Gaps in pix_valid stall loading without side effects.
- CLEAR (1 cycle): reset_acc=1, start=1, cnt_val=0; then ACCUM with idx=0.
- ACCUM (IMAGE_SIZE cycles):
  - start=0, reset_acc=0, cnt_val=idx.
  - idx increments each cycle; at idx==IMAGE_SIZE-1 go to SETTLE.
  - The node adds coef[cnt_val]*data[cnt_val] on each ACCUM edge.
- SETTLE (1 cycle):
  - start=1, cnt_val=0; node accumulators hold their final sums.
  - node_out_in is sampled into layer_out at the end of this cycle only; then go to OUT.
- OUT:
  - out_valid=1; layer_out held stable; pix_ready=0.
  - On out_valid && out_ready, clear out_valid and go to LOAD.
  - With out_ready held high, OUT lasts exactly 1 cycle.
- Defaults outside the states named above: start=1, reset_acc=0, cnt_val=0.
- img_data is written only in LOAD and is stable from CLEAR through OUT.
- Latency: if the last word is accepted in cycle t, CLEAR is t+1, ACCUM is t+2..t+IMAGE_SIZE+1, SETTLE is t+IMAGE_SIZE+2, and out_valid is first high in cycle t+IMAGE_SIZE+3 (67 cycles for 64 words).
- pix_ready returns in the cycle after the output handshake; there is no overlap between loading and computing.
- All outputs are registered or decoded from registered state only; there is no combinational path from pix_valid or out_ready to any output.

Decomposition:
- Package nn_pkg holds:
  - the 16-bit fixed-point word typedef fix_t;
  - IMAGE_SIZE and NUM_NODES defaults;
  - the CNT_W=7 constant;
  - the state enum {LOAD, CLEAR, ACCUM, SETTLE, OUT}.
- Sub-module image_buffer: serial write port (wr_en, wr_idx, wr_data), synchronous clear on rst, parallel read of all words; instantiated once.
- The FSM, index counters and capture register stay in node_layer_ctrl.

Test Plan:
1. Reset: rst high 2 cycles then low.
   - During rst: reset_acc=1, pix_ready=0.
   - First cycle after rst low: pix_ready=1, out_valid=0, all layer_out=0, busy=0.
2. Load and accumulate: load words 16'h0000+k for k=0..63 with pix_valid held high.
   - pix_ready is high 64 consecutive cycles and img_data[k]==k.
   - Next cycle: reset_acc=1 for exactly 1 cycle.
   - Then start=0 for exactly 64 cycles with cnt_val stepping 0..63.
   - Then start=1 and cnt_val=0.
3. Capture: stub drives node_out_in[j]=16'hFFFF during ACCUM and 16'hA000+j only during SETTLE.
   - out_valid rises exactly 67 cycles after the last word handshake.
   - layer_out[j]==16'hA000+j for every j.
4. Backpressure: out_ready low for 10 cycles after out_valid rises.
   - out_valid and layer_out hold; pix_ready=0; start=1; cnt_val=0.
   - Raise out_ready: handshake completes, and pix_ready=1 in the next cycle.
5. Gapped input: pix_valid high only every third cycle, values 16'h1234+k.
   - widx advances only on handshakes; reset_acc does not assert before the 64th handshake.
   - img_data[k]==16'h1234+k.
6. Reset mid-run: rst pulsed for 1 cycle while cnt_val==30.
   - Next cycle: pix_ready=1, busy=0, out_valid=0, img_data all 0.
   - A following full load produces a correct run identical to scenario 3.
